alu_pipe: RTL and testbench



---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_mdu_iter.sv | 102 ++++++++++
 rtl/alu_pipe.sv | 137 +++++++++++++
 tb/tb_alu_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, status bit positions and multiply/divide state encoding for the ALU pipeline.
package alu_pkg;

    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_NOR   = 5'd2;
    localparam logic [4:0] OP_XOR   = 5'd3;
    localparam logic [4:0] OP_ADD   = 5'd4;
    localparam logic [4:0] OP_SUB   = 5'd5;
    localparam logic [4:0] OP_SLT   = 5'd6;
    localparam logic [4:0] OP_SLTU  = 5'd7;
    localparam logic [4:0] OP_SRL   = 5'd8;
    localparam logic [4:0] OP_SLL   = 5'd9;
    localparam logic [4:0] OP_SRA   = 5'd10;
    localparam logic [4:0] OP_SRLV  = 5'd11;
    localparam logic [4:0] OP_SLLV  = 5'd12;
    localparam logic [4:0] OP_SRAV  = 5'd13;
    localparam logic [4:0] OP_MFHI  = 5'd14;
    localparam logic [4:0] OP_MFLO  = 5'd15;
    localparam logic [4:0] OP_MTHI  = 5'd16;
    localparam logic [4:0] OP_MTLO  = 5'd17;
    localparam logic [4:0] OP_MULT  = 5'd18;
    localparam logic [4:0] OP_MULTU = 5'd19;
    localparam logic [4:0] OP_DIV   = 5'd20;
    localparam logic [4:0] OP_DIVU  = 5'd21;

    localparam int ST_Z = 0;
    localparam int ST_N = 1;
    localparam int ST_C = 2;
    localparam int ST_V = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes; hi/lo carry the
// sign-corrected result once the step counter has run out.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(DW + 1);

    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   mag_q, hi_q, lo_q, hi_step, lo_step;
    logic            is_div_q, neg_q, neg_rem_q, div_zero_q;
    logic            signed_op, is_div, a_neg, b_neg;
    logic [DW-1:0]   a_mag, b_mag;
    logic [DW:0]     mul_sum, div_shift, div_diff;
    logic [2*DW-1:0] prod;

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        a_neg     = signed_op && a[DW-1];
        b_neg     = signed_op && b[DW-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
    end

    // Multiply: hi accumulates, lo shifts out multiplier bits. Divide: hi is the partial
    // remainder, lo shifts dividend bits out and quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : '0);
        div_shift = {hi_q, lo_q[DW-1]};
        div_diff  = div_shift - {1'b0, mag_q};
        if (is_div_q) begin
            if (!div_diff[DW]) begin
                hi_step = div_diff[DW-1:0];
                lo_step = {lo_q[DW-2:0], 1'b1};
            end else begin
                hi_step = div_shift[DW-1:0];
                lo_step = {lo_q[DW-2:0], 1'b0};
            end
        end else begin
            hi_step = mul_sum[DW:1];
            lo_step = {mul_sum[0], lo_q[DW-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            mag_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (start) begin
            cnt_q      <= CW'(DW);
            mag_q      <= is_div ? b_mag : a_mag;
            hi_q       <= '0;
            lo_q       <= is_div ? a_mag : b_mag;
            is_div_q   <= is_div;
            neg_q      <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= (b == '0);
        end else if (cnt_q != '0) begin
            hi_q  <= hi_step;
            lo_q  <= lo_step;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign done = (cnt_q == CW'(1));

    // Divide-by-zero keeps an all-ones quotient; the remainder (|A|) still takes A's sign.
    always_comb begin
        prod = {hi_q, lo_q};
        if (is_div_q) begin
            lo = div_zero_q ? '1 : (neg_q ? -lo_q : lo_q);
            hi = neg_rem_q ? -hi_q : hi_q;
        end else begin
            if (neg_q) begin
                prod = -prod;
            end
            hi = prod[2*DW-1:DW];
            lo = prod[DW-1:0];
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: registered single-cycle datapath plus an iterative mul/div unit that
// writes HI/LO; one output per accepted operation.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 5,
    parameter int STATUS_WIDTH = 4,
    parameter int SHAMT_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2*DATA_WIDTH-1:0] dataIn,
    input  logic [CTRL_WIDTH-1:0]   ctrl,
    input  logic [SHAMT_WIDTH-1:0]  shamt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   dataOut,
    output logic [STATUS_WIDTH-1:0] status,
    output logic                    busy
);

    localparam int DW = DATA_WIDTH;

    logic [1:0]              state_q, state_d;
    logic [DW-1:0]           hi_q, lo_q, a, b, res, mdu_hi, mdu_lo;
    logic [DW:0]             add_w, sub_w;
    logic                    c_flag, v_flag, slot_free, accept, is_md, mdu_done;
    logic [STATUS_WIDTH-1:0] flags, mdu_flags;

    assign a         = dataIn[2*DW-1:DW];
    assign b         = dataIn[DW-1:0];
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = rst_n && (state_q == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign is_md     = (ctrl == OP_MULT) || (ctrl == OP_MULTU) ||
                       (ctrl == OP_DIV) || (ctrl == OP_DIVU);

    always_comb begin
        res    = '0;
        c_flag = 1'b0;
        v_flag = 1'b0;
        add_w  = {1'b0, a} + {1'b0, b};
        sub_w  = {1'b0, a} - {1'b0, b};
        case (ctrl)
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_XOR:  res = a ^ b;
            OP_ADD: begin
                res    = add_w[DW-1:0];
                c_flag = add_w[DW];
                v_flag = (a[DW-1] == b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            OP_SUB: begin
                res    = sub_w[DW-1:0];
                c_flag = sub_w[DW];
                v_flag = (a[DW-1] != b[DW-1]) && (res[DW-1] != a[DW-1]);
            end
            OP_SLT:  res = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(DW-1){1'b0}}, (a < b)};
            OP_SRL:  res = b >> shamt;
            OP_SLL:  res = b << shamt;
            OP_SRA:  res = $unsigned($signed(b) >>> shamt);
            OP_SRLV: res = b >> a[SHAMT_WIDTH-1:0];
            OP_SLLV: res = b << a[SHAMT_WIDTH-1:0];
            OP_SRAV: res = $unsigned($signed(b) >>> a[SHAMT_WIDTH-1:0]);
            OP_MFHI: res = hi_q;
            OP_MFLO: res = lo_q;
            default: res = '0;
        endcase
        flags           = '0;
        flags[ST_Z]     = (res == '0);
        flags[ST_N]     = res[DW-1];
        flags[ST_C]     = c_flag;
        flags[ST_V]     = v_flag;
        mdu_flags       = '0;
        mdu_flags[ST_Z] = (mdu_lo == '0);
        mdu_flags[ST_N] = mdu_lo[DW-1];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && is_md) state_d = RUN;
            RUN:     if (mdu_done) state_d = FIX;
            FIX:     if (slot_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            dataOut   <= '0;
            status    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept && !is_md) begin
                out_valid <= 1'b1;
                dataOut   <= res;
                status    <= flags;
                if (ctrl == OP_MTHI) hi_q <= a;
                if (ctrl == OP_MTLO) lo_q <= a;
            end else if (state_q == FIX && slot_free) begin
                out_valid <= 1'b1;
                dataOut   <= mdu_lo;
                status    <= mdu_flags;
                hi_q      <= mdu_hi;
                lo_q      <= mdu_lo;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    alu_mdu_iter #(
        .DATA_WIDTH(DW)
    ) u_mdu (
        .clk  (clk),
        .rst_n(rst_n),
        .start(accept && is_md),
        .op   (ctrl),
        .a    (a),
        .b    (b),
        .done (mdu_done),
        .hi   (mdu_hi),
        .lo   (mdu_lo)
    );

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors push expected results, a monitor checks them.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [2*DW-1:0] dataIn = '0;
    logic [4:0]    ctrl = '0;
    logic [4:0]    shamt = '0;
    logic          in_ready, out_valid, busy;
    logic [DW-1:0] dataOut;
    logic [3:0]    status;

    int n_vec  = 0;
    int n_miss = 0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    alu_pipe #(
        .DATA_WIDTH  (DW),
        .CTRL_WIDTH  (5),
        .STATUS_WIDTH(4),
        .SHAMT_WIDTH (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dataIn   (dataIn),
        .ctrl     (ctrl),
        .shamt    (shamt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .dataOut  (dataOut),
        .status   (status),
        .busy     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens at the next posedge whenever both are high here.
    initial begin
        logic [35:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL spurious_out: got %h/%b, expected no output", dataOut, status);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {28'b0, status, dataOut}, {28'b0, e});
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] sh, input logic [DW-1:0] ed, input logic [3:0] es,
                         input bit want = 1'b1);
        int waited = 0;
        @(negedge clk);
        ctrl     = op;
        dataIn   = {a, b};
        shamt    = sh;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waited < 300) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL accept_timeout: op %0d not accepted, in_ready got 0, expected 1", op);
            in_valid = 1'b0;
            return;
        end
        if (want) exp_q.push_back({es, ed});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 300) begin
            @(negedge clk);
            #2;
            k++;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  ok;
        int  spur;

        // Reset values
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_data_status", {28'b0, status, dataOut}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Single-cycle ops
        issue(OP_ADD,  32'h7FFFFFFF, 32'h1,        0,  32'h80000000, 4'b1010);
        issue(OP_SUB,  32'h0,        32'h1,        0,  32'hFFFFFFFF, 4'b0110);
        issue(OP_SRA,  32'h0,        32'h80000000, 4,  32'hF8000000, 4'b0010);
        issue(OP_SRAV, 32'd36,       32'h80000000, 0,  32'hF8000000, 4'b0010);
        issue(OP_SLTU, 32'h1,        32'hFFFFFFFF, 0,  32'h1,        4'b0000);
        issue(OP_SLT,  32'h1,        32'hFFFFFFFF, 0,  32'h0,        4'b0001);
        issue(OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 0,  32'h00F000F0, 4'b0000);
        issue(OP_NOR,  32'h0,        32'h0,        0,  32'hFFFFFFFF, 4'b0010);
        issue(OP_XOR,  32'h1234ABCD, 32'h1234ABCD, 0,  32'h0,        4'b0001);
        issue(OP_SLL,  32'h0,        32'h1,        31, 32'h80000000, 4'b0010);
        issue(OP_SRL,  32'h0,        32'h80000000, 31, 32'h1,        4'b0000);
        issue(OP_SLLV, 32'd33,       32'h3,        0,  32'h6,        4'b0000);
        issue(5'd25,   32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'h0,        4'b0001);
        issue(OP_MTHI, 32'h12345678, 32'h0,        0,  32'h0,        4'b0001);
        issue(OP_MFHI, 32'h0,        32'h0,        0,  32'h12345678, 4'b0000);
        issue(OP_MTLO, 32'h80000001, 32'h0,        0,  32'h0,        4'b0001);
        issue(OP_MFLO, 32'h0,        32'h0,        0,  32'h80000001, 4'b0010);

        // MULT latency and busy/in_ready while running
        issue(OP_MULT, 32'hFFFFFFFE, 32'h3, 0, 32'hFFFFFFFA, 4'b0010);
        cyc = 0;
        ok  = 1'b1;
        while (cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
            if (out_valid) break;
            if (!(busy && !in_ready)) ok = 1'b0;
        end
        check("mult_latency", 64'(cyc), 64'd33);
        check("mult_busy_window", 64'(ok), 64'd1);
        check("mult_busy_clear", 64'(busy), 64'd0);
        issue(OP_MFHI,  32'h0,        32'h0,        0, 32'hFFFFFFFF, 4'b0010);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'h1,        4'b0000);
        issue(OP_MFHI,  32'h0,        32'h0,        0, 32'hFFFFFFFE, 4'b0010);

        // Division
        issue(OP_DIV,  32'hFFFFFFF9, 32'h2,        0, 32'hFFFFFFFD, 4'b0010);
        issue(OP_MFHI, 32'h0,        32'h0,        0, 32'hFFFFFFFF, 4'b0010);
        issue(OP_DIV,  32'h7,        32'hFFFFFFFE, 0, 32'hFFFFFFFD, 4'b0010);
        issue(OP_MFHI, 32'h0,        32'h0,        0, 32'h1,        4'b0000);
        issue(OP_DIVU, 32'h5,        32'h0,        0, 32'hFFFFFFFF, 4'b0010);
        issue(OP_MFHI, 32'h0,        32'h0,        0, 32'h5,        4'b0000);
        issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 4'b0010);
        issue(OP_MFHI, 32'h0,        32'h0,        0, 32'h0,        4'b0001);
        drain();

        // Backpressure: first result held, second op waits, then both drain in order
        @(negedge clk);
        out_ready = 1'b0;
        issue(OP_ADD, 32'h1, 32'h1, 0, 32'h2, 4'b0000);
        fork
            issue(OP_OR, 32'h4, 32'h1, 0, 32'h5, 4'b0000);
            begin
                ok = 1'b1;
                repeat (6) begin
                    @(negedge clk);
                    #2;
                    if (in_ready || !out_valid || dataOut !== 32'h2 || status !== 4'b0000) begin
                        ok = 1'b0;
                    end
                end
                check("bp_hold", 64'(ok), 64'd1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // MULT completing into a stalled consumer: result held, HI updated
        issue(OP_MULT, 32'h00010000, 32'h00010000, 0, 32'h0, 4'b0001);
        @(negedge clk);
        out_ready = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(negedge clk);
            #2;
            cyc++;
        end
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            if (!out_valid || dataOut !== 32'h0 || status !== 4'b0001 || busy || in_ready) begin
                ok = 1'b0;
            end
        end
        check("mul_bp_hold", 64'(ok), 64'd1);
        @(negedge clk);
        out_ready = 1'b1;
        issue(OP_MFHI, 32'h0, 32'h0, 0, 32'h1, 4'b0000);
        drain();

        // Reset in the middle of a divide
        issue(OP_DIV, 32'd100, 32'd7, 0, 32'h0, 4'h0, 1'b0);
        repeat (10) @(posedge clk);
        #2;
        check("midrst_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_data_status", {28'b0, status, dataOut}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        spur = 0;
        repeat (40) begin
            @(negedge clk);
            #2;
            if (out_valid) spur++;
        end
        check("midrst_no_output", 64'(spur), 64'd0);
        issue(OP_ADD,  32'h2, 32'h3, 0, 32'h5, 4'b0000);
        issue(OP_MFHI, 32'h0, 32'h0, 0, 32'h0, 4'b0001);
        issue(OP_MFLO, 32'h0, 32'h0, 0, 32'h0, 4'b0001);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
